vc_arbiter: RTL and testbench

Scheduler between the two virtual-channel FIFOs (VC0, VC1) and the two destination FIFOs (D0, D1) of the transmitter. It decides which VC FIFO is popped each cycle using weighted round-robin. It routes each popped word to D0 or D1 by bit 4 of the word, and holds off pops while either destination signals pause. It replaces the free-running combinational pop/demux logic and sits directly between the VC and destination FIFO instances, enabled by the control FSM.

---
 rtl/vc_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_vc_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_arbiter.sv
// vc_arbiter: weighted round-robin pop scheduler between two VC FIFOs with
// bit-4 routing of popped words to two destination FIFOs.
// Optional forwarded-word counters are built when VC_ARB_STATS_EN is defined.
module vc_arbiter #(
  parameter int unsigned DATA_WIDTH = 6,
  parameter int unsigned W0         = 3,
  parameter int unsigned W1         = 1
) (
  input  logic                  clk,
  input  logic                  RESET,
  input  logic                  active,
  input  logic                  VC0_EMPTY,
  input  logic                  VC1_EMPTY,
  input  logic                  VC0_VALID,
  input  logic                  VC1_VALID,
  input  logic [DATA_WIDTH-1:0] DATA_OUT_VC0,
  input  logic [DATA_WIDTH-1:0] DATA_OUT_VC1,
  input  logic                  D0_PAUSE,
  input  logic                  D1_PAUSE,
  input  logic                  D0_FULL,
  input  logic                  D1_FULL,
  output logic                  POP_VC0,
  output logic                  POP_VC1,
  output logic                  PUSH_D0,
  output logic                  PUSH_D1,
  output logic [DATA_WIDTH-1:0] data_to_D0,
  output logic [DATA_WIDTH-1:0] data_to_D1,
  output logic                  DROP_ERR,
  output logic [15:0]           cnt_d0,
  output logic [15:0]           cnt_d1
);

  typedef enum logic [1:0] {StIdle, StServe0, StServe1} state_e;

  localparam logic [3:0] BurstW0 = 4'(W0);
  localparam logic [3:0] BurstW1 = 4'(W1);

  state_e     state_q, state_d;
  logic [3:0] burst_q, burst_d;
  logic       last_q, last_d;
  logic       elig0, elig1;
  logic       grant0, grant1;

  // Destination is unknown before the pop, so either pause blocks both VCs.
  assign elig0 = active & ~VC0_EMPTY & ~D0_PAUSE & ~D1_PAUSE;
  assign elig1 = active & ~VC1_EMPTY & ~D0_PAUSE & ~D1_PAUSE;

  // Arbiter state register
  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q <= StIdle;
      burst_q <= 4'd0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      last_q  <= last_d;
    end
  end

  // Grant selection and next arbiter state
  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    grant0  = 1'b0;
    grant1  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Prefer the VC that was not served last.
        if (last_q ? elig0 : ~elig1 & elig0) begin
          grant0 = 1'b1;
        end else if (elig1) begin
          grant1 = 1'b1;
        end
      end
      StServe0: begin
        if (burst_q < BurstW0 && elig0) begin
          grant0  = 1'b1;
          burst_d = burst_q + 4'd1;
        end else if (elig1) begin
          grant1 = 1'b1;
        end else if (elig0) begin
          grant0 = 1'b1;
        end else begin
          state_d = StIdle;
          burst_d = 4'd0;
        end
      end
      StServe1: begin
        if (burst_q < BurstW1 && elig1) begin
          grant1  = 1'b1;
          burst_d = burst_q + 4'd1;
        end else if (elig0) begin
          grant0 = 1'b1;
        end else if (elig1) begin
          grant1 = 1'b1;
        end else begin
          state_d = StIdle;
          burst_d = 4'd0;
        end
      end
      default: begin
        state_d = StIdle;
        burst_d = 4'd0;
      end
    endcase
    // A grant that does not continue the current burst starts a new turn.
    if (grant0 && !(state_q == StServe0 && burst_d != 4'd1 && burst_d == burst_q + 4'd1)) begin
      state_d = StServe0;
      burst_d = 4'd1;
    end
    if (grant1 && !(state_q == StServe1 && burst_d != 4'd1 && burst_d == burst_q + 4'd1)) begin
      state_d = StServe1;
      burst_d = 4'd1;
    end
    last_d = grant1 ? 1'b1 : (grant0 ? 1'b0 : last_q);
  end

  // Pop outputs, suppressed while in reset
  always_comb begin
    POP_VC0 = grant0 & ~RESET;
    POP_VC1 = grant1 & ~RESET;
  end

  logic                  push_d0_q, push_d0_d;
  logic                  push_d1_q, push_d1_d;
  logic [DATA_WIDTH-1:0] data_d0_q, data_d0_d;
  logic [DATA_WIDTH-1:0] data_d1_q, data_d1_d;
  logic                  drop_err_q, drop_err_d;
  logic [DATA_WIDTH-1:0] word;

  // Route the popped word by bit 4; drop it if the destination is full.
  always_comb begin
    push_d0_d  = 1'b0;
    push_d1_d  = 1'b0;
    data_d0_d  = data_d0_q;
    data_d1_d  = data_d1_q;
    drop_err_d = drop_err_q;
    word       = VC0_VALID ? DATA_OUT_VC0 : DATA_OUT_VC1;
    if (VC0_VALID && VC1_VALID) begin
      drop_err_d = 1'b1;
    end
    if (VC0_VALID || VC1_VALID) begin
      if (word[4]) begin
        if (D1_FULL) begin
          drop_err_d = 1'b1;
        end else begin
          push_d1_d = 1'b1;
          data_d1_d = word;
        end
      end else begin
        if (D0_FULL) begin
          drop_err_d = 1'b1;
        end else begin
          push_d0_d = 1'b1;
          data_d0_d = word;
        end
      end
    end
  end

  // Routing registers; reset discards any in-flight word
  always_ff @(posedge clk) begin
    if (RESET) begin
      push_d0_q  <= 1'b0;
      push_d1_q  <= 1'b0;
      data_d0_q  <= '0;
      data_d1_q  <= '0;
      drop_err_q <= 1'b0;
    end else begin
      push_d0_q  <= push_d0_d;
      push_d1_q  <= push_d1_d;
      data_d0_q  <= data_d0_d;
      data_d1_q  <= data_d1_d;
      drop_err_q <= drop_err_d;
    end
  end

  assign PUSH_D0    = push_d0_q;
  assign PUSH_D1    = push_d1_q;
  assign data_to_D0 = data_d0_q;
  assign data_to_D1 = data_d1_q;
  assign DROP_ERR   = drop_err_q;

`ifdef VC_ARB_STATS_EN
  logic [15:0] cnt_d0_q, cnt_d0_d;
  logic [15:0] cnt_d1_q, cnt_d1_d;

  // Count each destination push; wraps at 16 bits
  always_comb begin
    cnt_d0_d = cnt_d0_q + {15'd0, push_d0_q};
    cnt_d1_d = cnt_d1_q + {15'd0, push_d1_q};
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (RESET) begin
      cnt_d0_q <= 16'd0;
      cnt_d1_q <= 16'd0;
    end else begin
      cnt_d0_q <= cnt_d0_d;
      cnt_d1_q <= cnt_d1_d;
    end
  end

  assign cnt_d0 = cnt_d0_q;
  assign cnt_d1 = cnt_d1_q;
`else
  assign cnt_d0 = 16'd0;
  assign cnt_d1 = 16'd0;
`endif

endmodule

// File: tb/tb_vc_arbiter.sv
// Bench for vc_arbiter: bench-side VC FIFOs as queues, a turn/quota model of
// the weighted round-robin, and an expected-output pipeline for routing.
module tb_vc_arbiter;
  localparam int DW = 6;
  localparam int W0 = 3;
  localparam int W1 = 1;

  logic          clk = 1'b0;
  logic          RESET, active, VC0_EMPTY, VC1_EMPTY, VC0_VALID, VC1_VALID;
  logic [DW-1:0] DATA_OUT_VC0, DATA_OUT_VC1;
  logic          D0_PAUSE, D1_PAUSE, D0_FULL, D1_FULL;
  logic          POP_VC0, POP_VC1, PUSH_D0, PUSH_D1, DROP_ERR;
  logic [DW-1:0] data_to_D0, data_to_D1;
  logic [15:0]   cnt_d0, cnt_d1;

  always #5 clk = ~clk;

  vc_arbiter #(.DATA_WIDTH(DW), .W0(W0), .W1(W1)) dut (
    .clk(clk), .RESET(RESET), .active(active),
    .VC0_EMPTY(VC0_EMPTY), .VC1_EMPTY(VC1_EMPTY),
    .VC0_VALID(VC0_VALID), .VC1_VALID(VC1_VALID),
    .DATA_OUT_VC0(DATA_OUT_VC0), .DATA_OUT_VC1(DATA_OUT_VC1),
    .D0_PAUSE(D0_PAUSE), .D1_PAUSE(D1_PAUSE), .D0_FULL(D0_FULL), .D1_FULL(D1_FULL),
    .POP_VC0(POP_VC0), .POP_VC1(POP_VC1), .PUSH_D0(PUSH_D0), .PUSH_D1(PUSH_D1),
    .data_to_D0(data_to_D0), .data_to_D1(data_to_D1), .DROP_ERR(DROP_ERR),
    .cnt_d0(cnt_d0), .cnt_d1(cnt_d1)
  );

  int checks = 0;
  int errors = 0;

  // Stimulus knobs, applied at the falling edge
  logic k_rst = 1'b1, k_act = 1'b0, k_p0 = 1'b0, k_p1 = 1'b0;
  logic k_f0 = 1'b0, k_f1 = 1'b0, k_fill = 1'b0;

  // Bench-side VC FIFOs and words presented on the read ports
  logic [DW-1:0] q0[$], q1[$];
  logic          mv0 = 1'b0, mv1 = 1'b0;
  logic [DW-1:0] md0 = '0, md1 = '0;

  // Model: current owner of the turn (-1 none), grants used this turn, last served VC
  int owner = -1, used = 0, last = 1;
  logic          ep0 = 1'b0, ep1 = 1'b0, edrop = 1'b0;
  logic [DW-1:0] ed0 = '0, ed1 = '0;
  logic [15:0]   ec0 = '0, ec1 = '0;

  // Per-cycle logs of sampled DUT outputs for literal checks
  int pop_log[$], push0_log[$], push1_log[$], data0_log[$], data1_log[$];
  int drop_log[$], cnt0_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int weight(input int vc);
    return (vc == 0) ? W0 : W1;
  endfunction

  task automatic clear_logs();
    pop_log.delete(); push0_log.delete(); push1_log.delete();
    data0_log.delete(); data1_log.delete(); drop_log.delete(); cnt0_log.delete();
  endtask

  // One clock cycle: drive, check every output against the model, advance the model.
  task automatic step();
    int            g, nowner, nused, pref;
    logic          el[2];
    logic [DW-1:0] w;
    @(negedge clk);
    RESET = k_rst; active = k_act; D0_PAUSE = k_p0; D1_PAUSE = k_p1;
    D0_FULL = k_f0; D1_FULL = k_f1;
    VC0_EMPTY = (q0.size() == 0); VC1_EMPTY = (q1.size() == 0);
    VC0_VALID = mv0; VC1_VALID = mv1; DATA_OUT_VC0 = md0; DATA_OUT_VC1 = md1;
    #1;
    el[0] = !k_rst && k_act && q0.size() != 0 && !k_p0 && !k_p1;
    el[1] = !k_rst && k_act && q1.size() != 0 && !k_p0 && !k_p1;
    g = -1; nowner = owner; nused = used;
    if (owner >= 0 && used < weight(owner) && el[owner]) begin
      g = owner; nused = used + 1;
    end else begin
      pref = (owner >= 0) ? 1 - owner : 1 - last;
      if (el[pref]) g = pref;
      else if (el[1 - pref]) g = 1 - pref;
      nowner = g; nused = (g >= 0) ? 1 : 0;
    end
    chk("pop_vc0", POP_VC0, g == 0);
    chk("pop_vc1", POP_VC1, g == 1);
    chk("push_d0", PUSH_D0, ep0);
    chk("push_d1", PUSH_D1, ep1);
    chk("data_d0", data_to_D0, ed0);
    chk("data_d1", data_to_D1, ed1);
    chk("drop_err", DROP_ERR, edrop);
    chk("cnt_d0", cnt_d0, ec0);
    chk("cnt_d1", cnt_d1, ec1);
    pop_log.push_back(POP_VC0 ? 0 : (POP_VC1 ? 1 : -1));
    push0_log.push_back(int'(PUSH_D0)); push1_log.push_back(int'(PUSH_D1));
    data0_log.push_back(int'(data_to_D0)); data1_log.push_back(int'(data_to_D1));
    drop_log.push_back(int'(DROP_ERR)); cnt0_log.push_back(int'(cnt_d0));
    @(posedge clk);
    if (k_rst) begin
      owner = -1; used = 0; last = 1;
      ep0 = 1'b0; ep1 = 1'b0; ed0 = '0; ed1 = '0; edrop = 1'b0;
      ec0 = '0; ec1 = '0; mv0 = 1'b0; mv1 = 1'b0;
    end else begin
`ifdef VC_ARB_STATS_EN
      ec0 = ec0 + 16'(ep0);
      ec1 = ec1 + 16'(ep1);
`endif
      ep0 = 1'b0; ep1 = 1'b0;
      if (mv0 || mv1) begin
        w = mv0 ? md0 : md1;
        if (mv0 && mv1) edrop = 1'b1;
        if (w[4]) begin
          if (k_f1) edrop = 1'b1;
          else begin ep1 = 1'b1; ed1 = w; end
        end else begin
          if (k_f0) edrop = 1'b1;
          else begin ep0 = 1'b1; ed0 = w; end
        end
      end
      owner = nowner; used = nused;
      if (g >= 0) last = g;
      mv0 = (g == 0); mv1 = (g == 1);
      if (g == 0) md0 = q0.pop_front();
      if (g == 1) md1 = q1.pop_front();
    end
    if (k_fill && $urandom_range(0, 2) == 0) q0.push_back(DW'($urandom));
    if (k_fill && $urandom_range(0, 2) == 0) q1.push_back(DW'($urandom));
  endtask

  task automatic do_reset();
    q0.delete(); q1.delete();
    k_rst = 1'b1; k_act = 1'b0; k_p0 = 1'b0; k_p1 = 1'b0; k_f0 = 1'b0; k_f1 = 1'b0;
    step(); step();
    k_rst = 1'b0;
    clear_logs();
  endtask

  initial begin
    int exp2_pop[8]   = '{0, 0, 0, 0, 0, -1, -1, -1};
    int exp2_push[8]  = '{0, 0, 1, 1, 1, 1, 1, 0};
    int exp3_pop[17]  = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 1, 1, 1, 1, 1, -1};
    int exp5_pop[12]  = '{0, 0, -1, -1, -1, 0, 0, 0, 0, -1, -1, -1};
    int exp5_push[12] = '{0, 0, 1, 1, 0, 0, 0, 1, 1, 1, 1, 0};
    int stats3;

    // Reset, then idle: no pops with empty FIFOs or with active low
    do_reset();
    k_act = 1'b1;
    step(); step();
    q0.push_back(6'h01); q0.push_back(6'h11);
    k_act = 1'b0;
    step(); step(); step();
    foreach (pop_log[i]) chk("idle_no_pop", pop_log[i], -1);
    chk("idle_push_d0", PUSH_D0, 0);
    chk("idle_data_d1", data_to_D1, 0);

    // VC0 alone with 5 words: 5 consecutive pops, pushes 2 cycles later
    do_reset();
    q0 = '{6'h01, 6'h12, 6'h03, 6'h14, 6'h05};
    k_act = 1'b1;
    for (int i = 0; i < 8; i++) step();
    for (int i = 0; i < 8; i++) begin
      chk("vc0_only_pop", pop_log[i], exp2_pop[i]);
      chk("vc0_only_push", push0_log[i] | push1_log[i], exp2_push[i]);
    end

    // Both VCs with 8 words: 3:1 weighted order, then the remaining VC every cycle
    do_reset();
    for (int i = 0; i < 8; i++) begin
      q0.push_back(DW'(i)); q1.push_back(DW'(8 + i));
    end
    k_act = 1'b1;
    for (int i = 0; i < 17; i++) step();
    for (int i = 0; i < 17; i++) chk("wrr_order", pop_log[i], exp3_pop[i]);

    // Routing by bit 4 from VC1
    do_reset();
    q1 = '{6'h05, 6'h15};
    k_act = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("route_push_d0", push0_log[2], 1);
    chk("route_data_d0", data0_log[2], 'h05);
    chk("route_nopush_d1", push1_log[2], 0);
    chk("route_push_d1", push1_log[3], 1);
    chk("route_data_d1", data1_log[3], 'h15);
    chk("route_single_d0", push0_log[3], 0);

    // D1 pause mid-stream: pops stop at once, two in-flight words still pushed
    do_reset();
    for (int i = 0; i < 6; i++) q0.push_back(DW'(6'h10 + i));
    k_act = 1'b1;
    step(); step();
    k_p1 = 1'b1;
    step(); step(); step();
    k_p1 = 1'b0;
    for (int i = 0; i < 7; i++) step();
    for (int i = 0; i < 12; i++) begin
      chk("pause_pop", pop_log[i], exp5_pop[i]);
      chk("pause_push_d1", push1_log[i], exp5_push[i]);
    end

    // D0 full on the 4th word: dropped, sticky error, counter holds at 3
    do_reset();
    q0 = '{6'h01, 6'h02, 6'h03, 6'h04};
    k_act = 1'b1;
    for (int i = 0; i < 4; i++) step();
    k_f0 = 1'b1;
    step();
    k_f0 = 1'b0;
    for (int i = 0; i < 4; i++) step();
`ifdef VC_ARB_STATS_EN
    stats3 = 3;
`else
    stats3 = 0;
`endif
    chk("full_push_ok", push0_log[4], 1);
    chk("full_no_push", push0_log[5], 0);
    chk("full_drop_before", drop_log[4], 0);
    chk("full_drop_set", drop_log[5], 1);
    chk("full_drop_sticky", drop_log[8], 1);
    chk("full_cnt_d0", cnt0_log[6], stats3);
    chk("full_cnt_d0_hold", cnt0_log[8], stats3);
    do_reset();
    chk("drop_cleared", drop_log.size() == 0 ? DROP_ERR : 1'b1, 0);

    // Randomized traffic with pauses, fulls, active toggling and occasional reset
    k_fill = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      k_rst = ($urandom_range(0, 199) == 0);
      k_act = ($urandom_range(0, 9) != 0);
      k_p0  = ($urandom_range(0, 9) == 0);
      k_p1  = ($urandom_range(0, 9) == 0);
      k_f0  = ($urandom_range(0, 9) == 0);
      k_f1  = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
